// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU pipeline front end.
package cpu_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        RST_WAIT,
        FETCH,
        STALLED,
        FLUSH
    } fetch_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/if_skid_reg.sv
// One-entry {inst, pc+4} holding register with a valid flag.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   clear_i            drop entry, data forced to NOP / 0 (highest priority)
//   load_i             capture inst_i / pc4_i, mark valid
//   unload_i           entry consumed, mark invalid (data kept)
//   inst_i, pc4_i      incoming instruction and its fetch address + 4
//   inst_o, pc4_o      held instruction and fetch address + 4
//   valid_o            entry holds an unconsumed instruction
module if_skid_reg
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (clear_i) begin
            inst_d  = INST_NOP;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (load_i) begin
            inst_d  = inst_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= INST_NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and
// feeds {inst, pc+4, valid} to IF/ID. A skid slot absorbs one response that
// lands while IF/ID stalls; a redirect flushes and restarts at the target.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   stall_i                        IF/ID not consuming the output this cycle
//   redirect_i, redirect_pc_i      taken branch / jump and its target
//   imem_req_o, imem_addr_o        memory request and word address
//   imem_ack_i, imem_rdata_i       one-cycle response strobe and data
//   inst_o, inst_addr_add_o        fetched instruction and its address + 4
//   inst_valid_o                   output holds an unconsumed instruction
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_add_o,
    output logic        inst_valid_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         req_q, req_d;

    logic         consume;
    logic         flush;
    logic         out_load, skid_load, skid_unload;
    logic [31:0]  out_inst_in, out_pc4_in, mem_pc4;
    logic [31:0]  skid_inst, skid_pc4;
    logic         skid_valid;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        flush       = 1'b0;
        out_load    = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        consume     = inst_valid_o && !stall_i;
        mem_pc4     = addr_q + PC_STEP;
        out_inst_in = imem_rdata_i;
        out_pc4_in  = mem_pc4;

        case (state_q)
            RST_WAIT: state_d = FETCH;
            FETCH: begin
                if (redirect_i) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc_i;
                    // Without an ack the old request is still open and its
                    // address must stay on the bus until it completes.
                    if (imem_ack_i) addr_d = redirect_pc_i;
                    else            state_d = FLUSH;
                end else if (imem_ack_i) begin
                    pc_d = pc_q + PC_STEP;
                    if (!inst_valid_o || consume) begin
                        out_load = 1'b1;
                        addr_d   = pc_q + PC_STEP;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = STALLED;
                    end
                end
            end
            STALLED: begin
                if (redirect_i) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc_i;
                    addr_d  = redirect_pc_i;
                    state_d = FETCH;
                end else if (consume && skid_valid) begin
                    out_load    = 1'b1;
                    out_inst_in = skid_inst;
                    out_pc4_in  = skid_pc4;
                    skid_unload = 1'b1;
                    addr_d      = pc_q;
                    state_d     = FETCH;
                end
            end
            FLUSH: begin
                if (redirect_i) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc_i;
                    if (imem_ack_i) begin
                        addr_d  = redirect_pc_i;
                        state_d = FETCH;
                    end
                end else if (imem_ack_i) begin
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            default: state_d = RST_WAIT;
        endcase

        // Request is registered from the next state so it is a flop output.
        req_d = (state_d == FETCH) || (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_WAIT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    if_skid_reg u_out_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (flush),
        .load_i   (out_load),
        .unload_i (consume),
        .inst_i   (out_inst_in),
        .pc4_i    (out_pc4_in),
        .inst_o   (inst_o),
        .pc4_o    (inst_addr_add_o),
        .valid_o  (inst_valid_o)
    );

    if_skid_reg u_skid_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .inst_i   (imem_rdata_i),
        .pc4_i    (mem_pc4),
        .inst_o   (skid_inst),
        .pc4_o    (skid_pc4),
        .valid_o  (skid_valid)
    );

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_add_o;
    logic        inst_valid_o;

    int unsigned lat = 0;
    int unsigned wait_cnt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: acks once the request has waited 'lat' cycles.
    assign imem_ack_i   = imem_req_o && (wait_cnt >= lat);
    assign imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        wait_cnt <= 0;
        else if (imem_req_o && !imem_ack_i) wait_cnt <= wait_cnt + 1;
        else                               wait_cnt <= 0;
    end

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .inst_o          (inst_o),
        .inst_addr_add_o (inst_addr_add_o),
        .inst_valid_o    (inst_valid_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; lat = 0;
        repeat (2) step();
        checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
        checks++; if (inst_o !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
        checks++; if (inst_addr_add_o !== 32'h0) begin failures++; $display("FAIL reset_pc4 got=%h exp=0", inst_addr_add_o); end
        rst_n = 1'b1;
        step();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL first_req got=%b/%h exp=1/0", imem_req_o, imem_addr_o); end
        checks++; if (inst_valid_o !== 1'b0) begin failures++; $display("FAIL first_valid_early got=%b exp=0", inst_valid_o); end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 5; k++) begin
            logic [31:0] a;
            a = 32'(4 * k);
            step();
            checks++; if (inst_valid_o !== 1'b1) begin failures++; $display("FAIL stream_valid k=%0d got=%b exp=1", k, inst_valid_o); end
            checks++; if (inst_addr_add_o !== a + 32'd4) begin failures++; $display("FAIL stream_pc4 k=%0d got=%h exp=%h", k, inst_addr_add_o, a + 32'd4); end
            checks++; if (inst_o !== mem_word(a)) begin failures++; $display("FAIL stream_inst k=%0d got=%h exp=%h", k, inst_o, mem_word(a)); end
            checks++; if (imem_addr_o !== a + 32'd4) begin failures++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, imem_addr_o, a + 32'd4); end
        end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (imem_req_o !== 1'b0) begin failures++; $display("FAIL stall_req c=%0d got=%b exp=0", c, imem_req_o); end
            checks++; if (inst_valid_o !== 1'b1 || inst_addr_add_o !== 32'd20 || inst_o !== mem_word(32'd16))
                begin failures++; $display("FAIL stall_hold c=%0d got=%b/%h/%h exp=1/00000014/%h", c, inst_valid_o, inst_addr_add_o, inst_o, mem_word(32'd16)); end
        end
        stall_i = 1'b0;
        step();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_add_o !== 32'd24 || inst_o !== mem_word(32'd20))
            begin failures++; $display("FAIL skid_out got=%b/%h/%h exp=1/00000018/%h", inst_valid_o, inst_addr_add_o, inst_o, mem_word(32'd20)); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd24) begin failures++; $display("FAIL skid_resume got=%b/%h exp=1/00000018", imem_req_o, imem_addr_o); end
        step();
        checks++; if (inst_addr_add_o !== 32'd28 || inst_o !== mem_word(32'd24))
            begin failures++; $display("FAIL post_skid got=%h/%h exp=0000001c/%h", inst_addr_add_o, inst_o, mem_word(32'd24)); end
    endtask

    task automatic test_flush();
        int n;
        lat = 3;
        step();
        checks++; if (inst_valid_o !== 1'b0 || imem_addr_o !== 32'd28) begin failures++; $display("FAIL wait1 got=%b/%h exp=0/0000001c", inst_valid_o, imem_addr_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'd28) begin failures++; $display("FAIL flush_hold got=%b/%h exp=1/0000001c", imem_req_o, imem_addr_o); end
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_addr_add_o !== 32'h0)
            begin failures++; $display("FAIL flush_bubble got=%b/%h/%h exp=0/0/0", inst_valid_o, inst_o, inst_addr_add_o); end
        step();
        checks++; if (imem_addr_o !== 32'd28) begin failures++; $display("FAIL flush_hold2 got=%h exp=0000001c", imem_addr_o); end
        step();
        checks++; if (imem_addr_o !== 32'h100 || inst_valid_o !== 1'b0 || inst_o !== 32'h0)
            begin failures++; $display("FAIL flush_discard got=%h/%b/%h exp=00000100/0/0", imem_addr_o, inst_valid_o, inst_o); end
        n = 0;
        while (inst_valid_o !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        checks++; if (n != 4) begin failures++; $display("FAIL flush_latency got=%0d exp=4", n); end
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_add_o !== 32'h104 || inst_o !== mem_word(32'h100))
            begin failures++; $display("FAIL flush_target got=%b/%h/%h exp=1/00000104/%h", inst_valid_o, inst_addr_add_o, inst_o, mem_word(32'h100)); end
    endtask

    task automatic test_redirect_ack();
        lat = 0;
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        step();
        redirect_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_addr_add_o !== 32'h0)
            begin failures++; $display("FAIL redir_ack_bubble got=%b/%h/%h exp=0/0/0", inst_valid_o, inst_o, inst_addr_add_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin failures++; $display("FAIL redir_ack_req got=%b/%h exp=1/00000200", imem_req_o, imem_addr_o); end
        step();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_add_o !== 32'h204 || inst_o !== mem_word(32'h200))
            begin failures++; $display("FAIL redir_ack_target got=%b/%h/%h exp=1/00000204/%h", inst_valid_o, inst_addr_add_o, inst_o, mem_word(32'h200)); end
    endtask

    task automatic test_redirect_stalled();
        stall_i = 1'b1;
        step();
        checks++; if (imem_req_o !== 1'b0 || inst_addr_add_o !== 32'h204) begin failures++; $display("FAIL skid_fill got=%b/%h exp=0/00000204", imem_req_o, inst_addr_add_o); end
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        step();
        redirect_i = 1'b0; stall_i = 1'b0;
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_addr_add_o !== 32'h0)
            begin failures++; $display("FAIL redir_stall_clear got=%b/%h/%h exp=0/0/0", inst_valid_o, inst_o, inst_addr_add_o); end
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin failures++; $display("FAIL redir_stall_req got=%b/%h exp=1/00000300", imem_req_o, imem_addr_o); end
        step();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_add_o !== 32'h304 || inst_o !== mem_word(32'h300))
            begin failures++; $display("FAIL redir_stall_target got=%b/%h/%h exp=1/00000304/%h", inst_valid_o, inst_addr_add_o, inst_o, mem_word(32'h300)); end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        checks++; if (imem_addr_o !== 32'hFFFF_FFFC || inst_valid_o !== 1'b0) begin failures++; $display("FAIL wrap_req got=%h/%b exp=fffffffc/0", imem_addr_o, inst_valid_o); end
        step();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_add_o !== 32'h0 || inst_o !== mem_word(32'hFFFF_FFFC))
            begin failures++; $display("FAIL wrap_out got=%b/%h/%h exp=1/00000000/%h", inst_valid_o, inst_addr_add_o, inst_o, mem_word(32'hFFFF_FFFC)); end
        checks++; if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=0", imem_addr_o); end
        step();
        checks++; if (inst_addr_add_o !== 32'h4 || inst_o !== mem_word(32'h0) || imem_addr_o !== 32'h4)
            begin failures++; $display("FAIL wrap_follow got=%h/%h/%h exp=00000004/%h/00000004", inst_addr_add_o, inst_o, imem_addr_o, mem_word(32'h0)); end
    endtask

    task automatic test_async_reset();
        stall_i = 1'b1; lat = 3;
        step();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || inst_valid_o !== 1'b1)
            begin failures++; $display("FAIL pre_reset got=%b/%h/%b exp=1/00000004/1", imem_req_o, imem_addr_o, inst_valid_o); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL async_req got=%b/%h exp=0/0", imem_req_o, imem_addr_o); end
        checks++; if (inst_valid_o !== 1'b0 || inst_o !== 32'h0 || inst_addr_add_o !== 32'h0)
            begin failures++; $display("FAIL async_out got=%b/%h/%h exp=0/0/0", inst_valid_o, inst_o, inst_addr_add_o); end
        stall_i = 1'b0; lat = 0;
        step();
        rst_n = 1'b1;
        step();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin failures++; $display("FAIL restart_req got=%b/%h exp=1/0", imem_req_o, imem_addr_o); end
        step();
        checks++; if (inst_valid_o !== 1'b1 || inst_addr_add_o !== 32'h4) begin failures++; $display("FAIL restart_out got=%b/%h exp=1/00000004", inst_valid_o, inst_addr_add_o); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_redirect_ack();
        test_redirect_stalled();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined CPU: owns the program counter, issues requests to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC+4 to the IF/ID pipeline register. It sits directly upstream of IF/ID. A one-entry skid slot absorbs a memory response that arrives while IF/ID is stalled. A redirect from the branch/jump resolver flushes in-flight work and restarts fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  IF/ID holding; the current output is not consumed this cycle
- redirect_i  in  1  branch taken / jump; flush and refetch
- redirect_pc_i  in  32  target address, valid with redirect_i
- imem_req_o  out  1  request valid
- imem_addr_o  out  32  request word address, stable while imem_req_o && !imem_ack_i
- imem_ack_i  in  1  one-cycle response strobe; may coincide with the first req cycle
- imem_rdata_i  in  32  instruction, valid with imem_ack_i
- inst_o  out  32  fetched instruction to IF/ID
- inst_addr_add_o  out  32  fetch address + 4 of inst_o
- inst_valid_o  out  1  inst_o/inst_addr_add_o hold an unconsumed instruction (drives IF/ID write enable)

## Operation
- Registers: pc (next address to fetch), addr (outstanding address), output slot {inst, pc+4, valid}, skid slot {inst, pc+4, valid}, state.
- Consume event: inst_valid_o && !stall_i.
- States:
  - RST_WAIT: imem_req_o=0. Goes to FETCH on the first cycle after reset release.
  - FETCH: imem_req_o=1, imem_addr_o=addr.
    - On ack with the output slot empty or being consumed: load the output slot, pc<=pc+4, addr<=pc+4, stay in FETCH.
    - On ack with the output slot full and not consumed: load the skid slot, pc<=pc+4, go to STALLED.
  - STALLED: imem_req_o=0. On consume, the skid slot moves to the output slot, addr<=pc, go to FETCH.
  - FLUSH: imem_req_o=1 with the stale addr held. On ack, discard the data, addr<=pc, go to FETCH.
- Redirect (highest priority, any state except RST_WAIT):
  - Effects: pc<=redirect_pc_i; output valid<=0; skid valid<=0; inst_o and inst_addr_add_o cleared to 0 (NOP bubble).
  - FETCH without ack that cycle: go to FLUSH, because the outstanding address must be held.
  - FETCH with ack that cycle: drop the data, addr<=redirect_pc_i, stay in FETCH.
  - STALLED or FLUSH: addr<=redirect_pc_i, go to FETCH. In FLUSH with no ack that cycle, stay in FLUSH instead.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. There is no alignment check.
- stall_i together with redirect_i: the redirect wins and the output is cleared regardless of the stall.

## Timing
- Reset values: imem_req_o=0, imem_addr_o=RESET_PC, inst_o=0, inst_addr_add_o=0, inst_valid_o=0, pc=RESET_PC, state=RST_WAIT. All outputs are registered.
- Latency: with same-cycle ack, the first instruction reaches inst_valid_o 2 cycles after rst_n rises. Sustained throughput is 1 instr/cycle.
- After a redirect with same-cycle ack, the target request is issued on the next cycle.
- A stall of N cycles holds the outputs for N cycles. At most one extra memory response is absorbed (skid). No request is issued while the skid is full.
- Reset mid-request: the outstanding transaction is abandoned. Memory must tolerate req dropping without ack on reset.

## Structure
- cpu_pkg holds:
  - fetch_state_t enum {RST_WAIT, FETCH, STALLED, FLUSH}
  - INST_NOP = 32'h0
  - PC_STEP = 32'd4
- Sub-module if_skid_reg: a one-entry {inst, pc+4} holding register with load/unload/clear and a valid flag. It is instantiated twice (output slot and skid slot).

## Test plan
- Reset, RESET_PC=0, memory acks same cycle → addresses 0,4,8 issued on consecutive cycles; inst_valid_o first high 2 cycles after reset release, inst_addr_add_o=4,8,12.
- stall_i high 3 cycles with same-cycle acks → output held 3 cycles; one response lands in the skid, then req low; after release, the skid value appears on the next cycle with no lost or duplicated instruction.
- 3-cycle memory latency, redirect to 0x100 in the second wait cycle → FLUSH; stale data discarded; next request addr=0x100; first valid output has inst_addr_add_o=0x104.
- Redirect coinciding with ack → that data is never visible; the next cycle requests the target; inst_valid_o=0 for that cycle.
- Redirect while stall_i=1 and skid full → both slots cleared, inst_o=0, inst_valid_o=0; fetch resumes at the target.
- Start at pc=0xFFFF_FFFC → inst_addr_add_o=0 and the next request addr=0; async rst_n asserted mid-wait → req=0 and outputs reset immediately, without waiting for a clock edge.
